// File: rtl/conv1d_frame_ctrl.sv
// -----------------------------------------------------------------------------
// conv1d_frame_ctrl
//
// Frame sequencer placed in front of a conv1d datapath. For every frame it
// pushes K-1 zero samples ahead of the data (flushing whatever history the
// previous frame left in conv1d), passes the frame samples through, then
// pushes K-1 trailing zeros so the convolution tail comes out. On the result
// side it drops the K-1 flush results and forwards exactly frame_len+K-1
// full-convolution results, flagging the final one with out_last.
//
// Ports
//   clk, rst            : clock, synchronous active-low reset
//   in_valid/in_ready   : upstream sample handshake
//   in_data, in_last    : sample and end-of-frame marker
//   conv_valid_in/_data_in   : stream into conv1d (data is 0 when not valid)
//   conv_valid_out/_data_out : results from conv1d (one per valid_in, in order)
//   out_valid/out_data/out_last : forwarded results, registered, no backpressure
//   busy                : registered "not idle"
//   frame_len           : samples accepted in the current/last frame
//   err_overrun         : sticky, a frame reached MAX_LEN without in_last
// -----------------------------------------------------------------------------
module conv1d_frame_ctrl #(
    parameter int DATA_W      = 8,
    parameter int GAIN_W      = 4,
    parameter int KERNEL_SIZE = 5,
    parameter int MAX_LEN     = 1024,
    parameter int LEN_W       = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_last,
    output logic                     conv_valid_in,
    output logic [DATA_W-1:0]        conv_data_in,
    input  logic                     conv_valid_out,
    input  logic [DATA_W+GAIN_W-1:0] conv_data_out,
    output logic                     out_valid,
    output logic [DATA_W+GAIN_W-1:0] out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic [LEN_W-1:0]         frame_len,
    output logic                     err_overrun
);

    localparam int PAD   = KERNEL_SIZE - 1;
    // clog2(K) bits always hold the value K-1
    localparam int PAD_W = $clog2(KERNEL_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        POST,
        DRAIN
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [PAD_W-1:0]     pad_cnt;
    logic [PAD_W-1:0]     drop_cnt;
    logic [LEN_W-1:0]     fwd_cnt;
    logic                 pad_done;
    logic                 accept;
    logic                 len_hit;

    assign pad_done = (pad_cnt == PAD_W'(PAD - 1));
    // The sample being accepted now is the MAX_LEN-th one
    assign len_hit  = (frame_len == LEN_W'(MAX_LEN - 1));

    always_comb begin
        state_nxt     = state;
        in_ready      = 1'b0;
        conv_valid_in = 1'b0;
        conv_data_in  = '0;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                // in_valid only starts the frame; the sample is taken in DATA
                if (in_valid) state_nxt = PRE;
            end
            PRE: begin
                conv_valid_in = 1'b1;
                if (pad_done) state_nxt = DATA;
            end
            DATA: begin
                in_ready      = 1'b1;
                accept        = in_valid;
                conv_valid_in = in_valid;
                conv_data_in  = in_valid ? in_data : '0;
                if (in_valid && (in_last || len_hit)) state_nxt = POST;
            end
            POST: begin
                conv_valid_in = 1'b1;
                if (pad_done) state_nxt = DRAIN;
            end
            DRAIN: begin
                // out_last is registered, so leaving here lands IDLE one cycle later
                if (out_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            pad_cnt     <= '0;
            drop_cnt    <= '0;
            fwd_cnt     <= '0;
            frame_len   <= '0;
            err_overrun <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);

            if ((state == PRE || state == POST) && !pad_done) begin
                pad_cnt <= pad_cnt + 1'b1;
            end else begin
                pad_cnt <= '0;
            end

            if (state == IDLE && in_valid) begin
                frame_len <= '0;
                drop_cnt  <= '0;
                fwd_cnt   <= '0;
            end

            if (accept) begin
                frame_len <= frame_len + 1'b1;
                if (len_hit && !in_last) err_overrun <= 1'b1;
            end

            // Result filter. Results seen while idle are leftovers from an
            // aborted frame and are ignored.
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            if (conv_valid_out && state != IDLE) begin
                if (drop_cnt != PAD_W'(PAD)) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end else begin
                    out_valid <= 1'b1;
                    out_data  <= conv_data_out;
                    // frame_len is final long before this index can be reached
                    out_last  <= (fwd_cnt == frame_len + LEN_W'(PAD - 1));
                    fwd_cnt   <= fwd_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/conv1d_frame_ctrl.md
# conv1d_frame_ctrl

Frame sequencer in front of the `conv1d` datapath. Accepts framed samples on a valid/ready stream and injects K-1 zero samples before each frame to flush the previous frame's history. Injects K-1 zeros after each frame to emit the convolution tail. Forwards exactly L+K-1 full-convolution results per L-sample frame, marking the last one, so frames never bleed into each other and `conv1d` never needs a reset between frames.

## Interface

Parameters:
- `DATA_W`, 8, sample width
- `GAIN_W`, 4, growth bits of `conv1d` output
- `KERNEL_SIZE`, 5, taps of the attached `conv1d` (K ≥ 2)
- `MAX_LEN`, 1024, maximum samples per frame
- `LEN_W`, 11, width of length counters; must satisfy 2^LEN_W > MAX_LEN+K

Ports:
- `clk`, in, 1, clock; all logic on rising edge
- `rst`, in, 1, synchronous, active-low reset
- `in_valid`, in, 1, upstream sample valid
- `in_ready`, out, 1, controller accepts sample
- `in_data`, in, DATA_W, sample
- `in_last`, in, 1, final sample of frame; qualified by `in_valid & in_ready`
- `conv_valid_in`, out, 1, to `conv1d.valid_in`
- `conv_data_in`, out, DATA_W, to `conv1d.data_in`
- `conv_valid_out`, in, 1, from `conv1d.valid_out`
- `conv_data_out`, in, DATA_W+GAIN_W, from `conv1d.data_out`
- `out_valid`, out, 1, forwarded result valid; no backpressure
- `out_data`, out, DATA_W+GAIN_W, forwarded result
- `out_last`, out, 1, final result of frame
- `busy`, out, 1, state ≠ IDLE
- `frame_len`, out, LEN_W, accepted sample count of current/last frame
- `err_overrun`, out, 1, sticky; frame hit MAX_LEN without `in_last`

## Operation

- `conv1d` is assumed to emit exactly one `valid_out` per `valid_in`, in order, at a fixed latency. The controller relies only on ordering, not on the latency value.
- States: IDLE, PRE, DATA, POST, DRAIN.
  - IDLE: `in_ready`=0. On `in_valid`=1, go to PRE; pre counter=0, `frame_len`=0, out counters cleared.
  - PRE: `conv_valid_in`=1, `conv_data_in`=0 for exactly K-1 cycles, then go to DATA.
  - DATA: `in_ready`=1. `conv_valid_in` = `in_valid & in_ready`; `conv_data_in` = `in_data`. Each accept increments `frame_len`. The frame ends when an accept has `in_last`=1, or when `frame_len` reaches MAX_LEN (the sample that reaches MAX_LEN is the last; sets `err_overrun`). On frame end, go to POST.
  - POST: zero injection, K-1 cycles, as in PRE; then go to DRAIN.
  - DRAIN: no injection. Wait until `out_last` is emitted, then return to IDLE.
- Output filter, on each `conv_valid_out`:
  - The first K-1 results of a frame are dropped (PRE flush).
  - The next `frame_len`+K-1 results are forwarded with `out_valid`=1 and `out_data` = `conv_data_out`.
  - `out_last`=1 on the forwarded result whose index equals `frame_len`+K-2. The final length is always latched before that result arrives.
- `conv_data_in` is 0 whenever `conv_valid_in`=0.
- Arithmetic: counters are unsigned LEN_W; no saturation is needed, given the LEN_W constraint. Data is passed through unmodified; no width change.
- `err_overrun` is cleared only by reset.

## Timing

- Reset (`rst`=0 at a clock edge): state=IDLE. All outputs are 0 (`in_ready`, `conv_valid_in`, `conv_data_in`, `out_valid`, `out_data`, `out_last`, `busy`, `frame_len`, `err_overrun`). A reset mid-frame aborts the frame; no `out_last` is emitted, and the next frame's PRE flushes stale `conv1d` history.
- Counting from cycle t, where IDLE sees `in_valid`=1:
  - PRE drives zeros in cycles t+1 … t+K-1.
  - `in_ready` is first 1 in cycle t+K.
  - An `in_valid` held in IDLE is not consumed until DATA.
- `in_valid` gaps in DATA are allowed and stall the frame; no zeros are inserted.
- The cycle after the last accept begins POST.
- `in_ready`=0 throughout PRE, POST and DRAIN.
- Output path is registered: `out_valid`/`out_data`/`out_last` appear one cycle after the corresponding `conv_valid_out`.
- `busy` is registered with state.
- DRAIN → IDLE occurs in the cycle after `out_last`. The earliest next frame starts PRE one cycle after that.
- A single-sample frame (`in_last` on the first accept) is legal and yields K results.

## Test plan

- K=5, conv1d stand-in = 2-cycle delay. Frame [1,2,3]:
  - `conv_data_in` sequence with valid: 0,0,0,0,1,2,3,0,0,0,0.
  - 4 results dropped; `out_data` 1,2,3,0,0,0,0 with `out_last` on the 7th only.
  - `frame_len`=3.
- Real `conv1d`, all-ones kernel behaviour. Frame [1,2,3,4,5] then frame [10]:
  - First frame outputs 1,3,6,10,15,14,12,9,5.
  - Second frame outputs 10,10,10,10,10, with no leakage from frame 1.
- `in_valid` toggling 1,0,0,1,1 in DATA (frame of 3 with `in_last` on the third accept): only 3 accepts and 3 nonzero `conv_valid_in` data pulses; 7 results forwarded.
- MAX_LEN=4, frame of 6 samples without `in_last`:
  - Accepts stop after 4; `err_overrun`=1; 8 results forwarded, last flagged.
  - IDLE follows; the remaining samples start a new frame.
- `rst`=0 asserted in the 2nd DATA cycle, then released, then frame [7]:
  - All outputs 0 during reset.
  - The new frame yields 7,0,0,0,0 with `out_last` on the 5th.
  - `err_overrun`=0.
- Single-sample frame [9], stand-in delay:
  - Outputs 9,0,0,0,0; `out_last` on the 5th.
  - `busy` falls the cycle after `out_last`.
